ddma_send_sched: RTL and testbench

DDMA_SEND_SCHED -- requirements
Module: ddma_send_sched

---
 rtl/ddma_sched_pkg.sv | 19 +
 rtl/ddma_send_sched_desc_fifo.sv | 52 +++++
 rtl/ddma_send_sched.sv | 120 ++++++++++++
 tb/tb_ddma_send_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddma_sched_pkg.sv
// ddma_sched_pkg: FSM state and descriptor types shared by the DDMA send scheduler
package ddma_sched_pkg;

    localparam int DESC_MEM_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_RELEASE
    } sched_state_t;

    typedef struct packed {
        logic [7:0]            dest;
        logic [DESC_MEM_W-1:0] addr;
        logic [DESC_MEM_W-1:0] size;
    } desc_t;

endpackage

// File: rtl/ddma_send_sched_desc_fifo.sv
// desc_fifo: descriptor ring with push, pop and a flush that can spare the in-flight head
module desc_fifo
    import ddma_sched_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_push,
    input  desc_t         i_desc,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic          i_keep_head,
    output desc_t         o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    desc_t         r_mem [DEPTH];
    logic [AW-1:0] r_rptr, r_wptr;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop, w_keep;
    logic [AW-1:0] w_rptr_n;

    assign o_full   = r_count == CW'(DEPTH);
    assign o_empty  = r_count == '0;
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rptr];
    // a full queue refuses pushes even when a pop frees a slot this cycle
    assign w_push   = i_push && !o_full && !i_flush;
    assign w_pop    = i_pop && !o_empty;
    assign w_keep   = i_keep_head && !w_pop && !o_empty;
    assign w_rptr_n = r_rptr + AW'(w_pop);

    always_ff @(posedge clock)
        if (w_push) r_mem[r_wptr] <= i_desc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_rptr  <= w_rptr_n;
            r_wptr  <= i_flush ? w_rptr_n + AW'(w_keep) : r_wptr + AW'(w_push);
            r_count <= i_flush ? CW'(w_keep) : r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/ddma_send_sched.sv
// ddma_send_sched: queues MMIO descriptors and hands them one at a time to the DDMA engine
// Optional ack timeout with error flag: define DDMA_SCHED_TIMEOUT_EN.
module ddma_send_sched
    import ddma_sched_pkg::*;
#(
    parameter int MEMORY_WIDTH   = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enq_valid_in,
    input  logic [7:0]                 enq_dest_in,
    input  logic [MEMORY_WIDTH-1:0]    enq_addr_in,
    input  logic [MEMORY_WIDTH-1:0]    enq_size_in,
    output logic                       enq_ready_out,
    input  logic                       flush_in,
    input  logic                       send_ack_in,
    output logic [7:0]                 send_dest_out,
    output logic [MEMORY_WIDTH-1:0]    send_addr_out,
    output logic [MEMORY_WIDTH-1:0]    send_size_out,
    output logic                       send_cmd_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       busy_out,
    output logic                       done_irq_out,
    output logic                       error_out
);
    sched_state_t            r_state, w_state_n;
    desc_t                   w_head, w_enq_desc;
    logic                    w_empty, w_full, w_go, w_load, w_skip, w_retire, w_pop, w_timeout;
    logic [7:0]              r_dest;
    logic [MEMORY_WIDTH-1:0] r_addr, r_size;
    logic                    r_done;

    assign w_enq_desc = {enq_dest_in, DESC_MEM_W'(enq_addr_in), DESC_MEM_W'(enq_size_in)};

    desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (enq_valid_in),
        .i_desc      (w_enq_desc),
        .i_pop       (w_pop),
        .i_flush     (flush_in),
        .i_keep_head (r_state != ST_IDLE),
        .o_head      (w_head),
        .o_count     (count_out),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // a flush seen in IDLE empties the queue, so nothing is started that cycle
    assign w_go     = r_state == ST_IDLE && !w_empty && !flush_in;
    assign w_skip   = w_go && w_head.size == '0;
    assign w_load   = w_go && w_head.size != '0;
    assign w_retire = w_skip || (r_state == ST_RELEASE && !send_ack_in);
    assign w_pop    = w_retire || w_timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_dest  <= '0;
            r_addr  <= '0;
            r_size  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_done  <= w_retire;
            if (w_load) begin
                r_dest <= w_head.dest;
                r_addr <= MEMORY_WIDTH'(w_head.addr);
                r_size <= MEMORY_WIDTH'(w_head.size);
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE:     w_state_n = w_load ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:    w_state_n = ST_WAIT_ACK;
            ST_WAIT_ACK: w_state_n = send_ack_in ? ST_RELEASE : w_timeout ? ST_IDLE : ST_WAIT_ACK;
            default:     w_state_n = send_ack_in ? ST_RELEASE : ST_IDLE;
        endcase
    end

    always_comb begin
        send_cmd_out = r_state == ST_ISSUE || r_state == ST_WAIT_ACK;
        busy_out     = r_state != ST_IDLE;
    end

    assign send_dest_out = r_dest;
    assign send_addr_out = r_addr;
    assign send_size_out = r_size;
    assign done_irq_out  = r_done;
    assign enq_ready_out = !w_full;

`ifdef DDMA_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;
    logic          r_err;

    // r_tmo counts completed WAIT_ACK cycles; the last allowed one gives up
    assign w_timeout = r_state == ST_WAIT_ACK && !send_ack_in && r_tmo == TW'(TIMEOUT_CYCLES - 1);
    assign error_out = r_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= r_state == ST_WAIT_ACK ? r_tmo + TW'(1) : '0;
            r_err <= r_err | w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_ddma_send_sched.sv
// tb_ddma_send_sched: directed scoreboard bench with a DDMA ack responder model
module tb_ddma_send_sched;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enq_valid_in = 1'b0;
    logic [7:0]  enq_dest_in = '0;
    logic [31:0] enq_addr_in = '0;
    logic [31:0] enq_size_in = '0;
    logic        enq_ready_out;
    logic        flush_in = 1'b0;
    logic        send_ack_in = 1'b0;
    logic [7:0]  send_dest_out;
    logic [31:0] send_addr_out, send_size_out;
    logic        send_cmd_out;
    logic [2:0]  count_out;
    logic        busy_out, done_irq_out, error_out;

    int          n_pass = 0, n_total = 0, n_issue = 0, n_done = 0;
    int          ack_delay = 3, ack_hold = 2;
    logic        ack_en = 1'b1;
    int          ph = 0, cnt = 0;
    logic        prev_cmd = 1'b0;
    logic [71:0] exp_q[$];
    logic [71:0] d;
    logic [7:0]  cap_dest;
    logic [31:0] cap_addr, cap_size;
    int          b_i, b_d;

    always #5 clock = ~clock;

    ddma_send_sched #(.MEMORY_WIDTH(32), .DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .enq_valid_in(enq_valid_in), .enq_dest_in(enq_dest_in),
        .enq_addr_in(enq_addr_in), .enq_size_in(enq_size_in),
        .enq_ready_out(enq_ready_out), .flush_in(flush_in), .send_ack_in(send_ack_in),
        .send_dest_out(send_dest_out), .send_addr_out(send_addr_out),
        .send_size_out(send_size_out), .send_cmd_out(send_cmd_out),
        .count_out(count_out), .busy_out(busy_out),
        .done_irq_out(done_irq_out), .error_out(error_out)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic enq(logic [7:0] dd, logic [31:0] a, logic [31:0] s, logic acc, logic iss);
        enq_valid_in = 1'b1;
        enq_dest_in  = dd;
        enq_addr_in  = a;
        enq_size_in  = s;
        check("enq_ready", enq_ready_out, acc);
        if (acc && iss) exp_q.push_back({dd, a, s});
        tick();
        enq_valid_in = 1'b0;
    endtask

    task automatic wait_issue(int target, int budget);
        for (int i = 0; i < budget && n_issue < target; i++) tick();
        check("wait_issue", n_issue >= target, 1);
    endtask

    task automatic wait_done(int target, int budget);
        for (int i = 0; i < budget && n_done < target; i++) tick();
        check("wait_done", n_done >= target, 1);
    endtask

    // DDMA model: raises ack ack_delay cycles after cmd rises, holds it ack_hold cycles;
    // also scoreboards each issued descriptor and checks send_* stay put while busy
    always @(negedge clock) begin
        if (reset) begin
            ph = 0;
            send_ack_in = 1'b0;
            prev_cmd = 1'b0;
        end else begin
            if (ph == 1) begin
                if (cnt <= 1) begin
                    send_ack_in = 1'b1;
                    ph = 2;
                    cnt = ack_hold;
                end else cnt--;
            end else if (ph == 2) begin
                if (cnt <= 1) begin
                    send_ack_in = 1'b0;
                    ph = 0;
                end else cnt--;
            end
            if (done_irq_out) n_done++;
            if (send_cmd_out && !prev_cmd) begin
                n_issue++;
                check("issue_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    d = exp_q.pop_front();
                    check("issue_dest", send_dest_out, d[71:64]);
                    check("issue_addr", send_addr_out, d[63:32]);
                    check("issue_size", send_size_out, d[31:0]);
                end
                cap_dest = send_dest_out;
                cap_addr = send_addr_out;
                cap_size = send_size_out;
                if (ack_en) begin
                    ph = 1;
                    cnt = ack_delay;
                end
            end else if (busy_out) begin
                check("stable_dest", send_dest_out, cap_dest);
                check("stable_addr", send_addr_out, cap_addr);
                check("stable_size", send_size_out, cap_size);
            end
            prev_cmd = send_cmd_out;
        end
    end

    initial begin
        #3;
        check("rst_ready", enq_ready_out, 1);
        check("rst_count", count_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_cmd", send_cmd_out, 0);
        check("rst_done", done_irq_out, 0);
        check("rst_error", error_out, 0);
        check("rst_dest", send_dest_out, 0);
        check("rst_addr", send_addr_out, 0);
        check("rst_size", send_size_out, 0);
        tick(2);
        reset = 1'b0;
        tick();

        b_i = n_issue; b_d = n_done;
        enq(8'h11, 32'h4000_0100, 32'd8, 1'b1, 1'b1);
        check("t1_count1", count_out, 1);
        wait_done(b_d + 1, 50);
        tick();
        check("t1_count0", count_out, 0);
        check("t1_issues", n_issue - b_i, 1);
        check("t1_dones", n_done - b_d, 1);

        b_i = n_issue; b_d = n_done;
        enq(8'h21, 32'h1000_0000, 32'd1, 1'b1, 1'b1);
        enq(8'h22, 32'h1000_0040, 32'd2, 1'b1, 1'b1);
        enq(8'h23, 32'h1000_0080, 32'd3, 1'b1, 1'b1);
        enq(8'h24, 32'h1000_00C0, 32'd4, 1'b1, 1'b1);
        enq(8'h25, 32'h1000_0100, 32'd5, 1'b0, 1'b0);
        check("t2_count4", count_out, 4);
        wait_done(b_d + 4, 200);
        tick(5);
        check("t2_issues", n_issue - b_i, 4);
        check("t2_dones", n_done - b_d, 4);
        check("t2_q_empty", exp_q.size(), 0);
        check("t2_count0", count_out, 0);

        b_i = n_issue; b_d = n_done;
        enq(8'h31, 32'h2000_0000, 32'd0, 1'b1, 1'b0);
        enq(8'h32, 32'h2000_0100, 32'd4, 1'b1, 1'b1);
        wait_done(b_d + 2, 60);
        tick(3);
        check("t3_issues", n_issue - b_i, 1);
        check("t3_dones", n_done - b_d, 2);
        check("t3_count0", count_out, 0);

        ack_delay = 6;
        b_i = n_issue; b_d = n_done;
        enq(8'h41, 32'h3000_0000, 32'd16, 1'b1, 1'b1);
        enq(8'h42, 32'h3000_0100, 32'd16, 1'b1, 1'b0);
        enq(8'h43, 32'h3000_0200, 32'd16, 1'b1, 1'b0);
        wait_issue(b_i + 1, 20);
        tick(2);
        check("t4_count3", count_out, 3);
        flush_in = 1'b1;
        enq_valid_in = 1'b1;
        enq_dest_in = 8'h99;
        enq_size_in = 32'd7;
        tick();
        flush_in = 1'b0;
        enq_valid_in = 1'b0;
        check("t4_count1", count_out, 1);
        check("t4_busy", busy_out, 1);
        wait_done(b_d + 1, 60);
        tick(10);
        check("t4_count0", count_out, 0);
        check("t4_issues", n_issue - b_i, 1);
        check("t4_dones", n_done - b_d, 1);
        check("t4_busy0", busy_out, 0);

`ifdef DDMA_SCHED_TIMEOUT_EN
        ack_delay = 3;
        ack_en = 1'b0;
        b_i = n_issue; b_d = n_done;
        enq(8'h51, 32'h5000_0000, 32'd2, 1'b1, 1'b1);
        enq(8'h52, 32'h5000_0100, 32'd2, 1'b1, 1'b1);
        check("t5_error0", error_out, 0);
        wait_issue(b_i + 1, 20);
        ack_en = 1'b1;
        wait_issue(b_i + 2, 60);
        check("t5_error1", error_out, 1);
        wait_done(b_d + 1, 60);
        tick(5);
        check("t5_dones", n_done - b_d, 1);
        check("t5_issues", n_issue - b_i, 2);
        check("t5_count0", count_out, 0);
`endif

        ack_delay = 6;
        b_i = n_issue;
        enq(8'h61, 32'h6000_0000, 32'd9, 1'b1, 1'b1);
        enq(8'h62, 32'h6000_0100, 32'd9, 1'b1, 1'b0);
        wait_issue(b_i + 1, 20);
        tick(2);
        b_d = n_done;
        #2 reset = 1'b1;
        #1;
        check("r_cmd", send_cmd_out, 0);
        check("r_busy", busy_out, 0);
        check("r_count", count_out, 0);
        check("r_ready", enq_ready_out, 1);
        check("r_addr", send_addr_out, 0);
        check("r_dest", send_dest_out, 0);
        check("r_done", done_irq_out, 0);
        check("r_error", error_out, 0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(8);
        check("r_no_done", n_done - b_d, 0);
        check("r_count_after", count_out, 0);
        check("r_busy_after", busy_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
